// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings and the default width.
package div_iter_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          borrow;

  assign shifted = {rem_i, bit_i};
  assign trial   = shifted - {1'b0, divisor_i};
  // rem_i < divisor_i always holds, so a non-negative trial stays below 2^XLEN and the
  // top bit of the XLEN+1-bit difference is exactly the borrow.
  assign borrow  = trial[XLEN];

  assign q_bit_o = ~borrow;
  assign rem_o   = borrow ? shifted[XLEN-1:0] : trial[XLEN-1:0];

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider (signed/unsigned) with start/ready input and valid/ready output
// handshakes; divide-by-zero and signed overflow complete early with RISC-V M results.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            ready_o,
  output logic            valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o,
  output logic            busy_o
);

  div_state_e state_q, state_d;

  logic [XLEN-1:0]  prem_q;      // partial remainder
  logic [XLEN-1:0]  shreg_q;     // dividend bits out at the top, quotient bits in at the bottom
  logic [XLEN-1:0]  dvs_q;       // divisor magnitude
  logic [CNT_W-1:0] cnt_q;
  logic             is_signed_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [XLEN-1:0]  quot_out_q;
  logic [XLEN-1:0]  rem_out_q;

  logic            accept;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic            neg_quot;
  logic            neg_rem;

  assign accept   = start_i & (state_q == DIV_IDLE) & ~flush_i;
  assign div_zero = (divisor_i == '0);
  assign overflow = signed_i & (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor_i);

  // The most negative value negates to itself, which read as unsigned is 2^(XLEN-1).
  assign mag_a = (signed_i & dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
  assign mag_b = (signed_i & divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

  assign neg_quot = is_signed_q & (sign_a_q ^ sign_b_q);
  assign neg_rem  = is_signed_q & sign_a_q;

  div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem_i    (prem_q),
    .bit_i    (shreg_q[XLEN-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (accept) state_d = (div_zero | overflow) ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt_q == CNT_W'(1)) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_DONE;
      DIV_DONE: if (out_ready_i) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush_i) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      prem_q      <= '0;
      shreg_q     <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      quot_out_q  <= '0;
      rem_out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_signed_q <= signed_i;
        sign_a_q    <= dividend_i[XLEN-1];
        sign_b_q    <= divisor_i[XLEN-1];
        prem_q      <= '0;
        shreg_q     <= mag_a;
        dvs_q       <= mag_b;
        cnt_q       <= CNT_W'(XLEN);
        if (div_zero) begin
          quot_out_q <= '1;
          rem_out_q  <= dividend_i;
        end else if (overflow) begin
          quot_out_q <= dividend_i;
          rem_out_q  <= '0;
        end
      end else if (!flush_i && state_q == DIV_CALC) begin
        prem_q  <= step_rem;
        shreg_q <= {shreg_q[XLEN-2:0], step_q};
        cnt_q   <= cnt_q - CNT_W'(1);
      end else if (!flush_i && state_q == DIV_FIX) begin
        quot_out_q <= neg_quot ? -shreg_q : shreg_q;
        rem_out_q  <= neg_rem ? -prem_q : prem_q;
      end
    end
  end

  assign ready_o = (state_q == DIV_IDLE);
  assign valid_o = (state_q == DIV_DONE);
  assign busy_o  = (state_q == DIV_CALC) | (state_q == DIV_FIX);
  assign quot_o  = quot_out_q;
  assign rem_o   = rem_out_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter (XLEN=32): directed vector table, random ops against a
// reference model, and hand-written backpressure/flush/reset sequences.
module tb_div_iter;

  localparam int unsigned XLEN = 32;

  logic            clk_i;
  logic            rst_n;
  logic            flush_i;
  logic            start_i;
  logic            signed_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            ready_o;
  logic            valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] quot_o;
  logic [XLEN-1:0] rem_o;
  logic            busy_o;

  int n_assert;
  int n_fail;

  div_iter #(
    .XLEN(XLEN)
  ) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .out_ready_i(out_ready_i),
    .quot_o     (quot_o),
    .rem_o      (rem_o),
    .busy_o     (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic void model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output int lat);
    lat = 34;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0; lat = 1;
    end else if (sg) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Starts at a negedge with the unit idle; ends at a negedge with the unit idle again.
  task automatic do_op(input string tag, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                       input int elat);
    int lat;
    check({tag, " ready before"}, 64'(ready_o), 64'd1);
    start_i = 1'b1; signed_i = sg; dividend_i = a; divisor_i = b; out_ready_i = 1'b1;
    @(posedge clk_i);
    lat = 1;
    @(negedge clk_i);
    start_i = 1'b0;
    while (!valid_o && lat < 200) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
    end
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " quot"}, 64'(quot_o), 64'(eq));
    check({tag, " rem"}, 64'(rem_o), 64'(er));
    @(posedge clk_i);
    @(negedge clk_i);
    check({tag, " ready after"}, 64'(ready_o), 64'd1);
  endtask

  initial begin
    logic [31:0] mq, mr;
    int          mlat;
    int          lat;
    logic        seen;

    n_assert = 0;
    n_fail   = 0;

    //            sg    dividend       divisor        quot           rem            lat
    vecs.push_back('{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         34});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 34});
    vecs.push_back('{1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1,         34});
    vecs.push_back('{1'b1, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1});
    vecs.push_back('{1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34});
    vecs.push_back('{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         34});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 34});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         34});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         34});
    vecs.push_back('{1'b0, 32'd5,         32'd10,        32'd0,         32'd5,         34});
    vecs.push_back('{1'b1, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF8, 1});
    vecs.push_back('{1'b0, 32'd0,         32'd3,         32'd0,         32'd0,         34});

    rst_n = 1'b0; flush_i = 1'b0; start_i = 1'b0; signed_i = 1'b0;
    dividend_i = '0; divisor_i = '0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset ready", 64'(ready_o), 64'd1);
    check("reset valid", 64'(valid_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset quot", 64'(quot_o), 64'd0);
    check("reset rem", 64'(rem_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk_i);

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
            vecs[i].lat);
    end

    for (int i = 0; i < 16; i++) begin
      logic        sg;
      logic [31:0] a, b;
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      model(sg, a, b, mq, mr, mlat);
      do_op($sformatf("rand%0d", i), sg, a, b, mq, mr, mlat);
    end

    // Backpressure: result held, stray starts ignored while DONE.
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
    out_ready_i = 1'b0;
    @(posedge clk_i);
    lat = 1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("bp busy in calc", 64'(busy_o), 64'd1);
    while (!valid_o && lat < 200) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
    end
    check("bp latency", 64'(lat), 64'd34);
    for (int i = 0; i < 5; i++) begin
      start_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
      @(posedge clk_i);
      @(negedge clk_i);
      check($sformatf("bp%0d valid", i), 64'(valid_o), 64'd1);
      check($sformatf("bp%0d ready", i), 64'(ready_o), 64'd0);
      check($sformatf("bp%0d quot", i), 64'(quot_o), 64'd14);
      check($sformatf("bp%0d rem", i), 64'(rem_o), 64'd2);
    end
    start_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("bp release valid", 64'(valid_o), 64'd0);
    check("bp release ready", 64'(ready_o), 64'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    check("bp no stray accept", 64'(busy_o), 64'd0);

    // Flush at CALC iteration 10.
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    check("flush busy before", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush ready", 64'(ready_o), 64'd1);
    check("flush busy", 64'(busy_o), 64'd0);
    check("flush valid", 64'(valid_o), 64'd0);
    check("flush quot kept", 64'(quot_o), 64'd14);
    check("flush rem kept", 64'(rem_o), 64'd2);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
    end
    check("flush no valid", 64'(seen), 64'd0);
    do_op("after flush 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34);

    // Flush wins over start in IDLE.
    start_i = 1'b1; flush_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush+start ready", 64'(ready_o), 64'd1);
    check("flush+start busy", 64'(busy_o), 64'd0);

    // Reset mid-CALC.
    start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'hFFFF_FFF9; divisor_i = 32'd2;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    rst_n = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("midreset ready", 64'(ready_o), 64'd1);
    check("midreset valid", 64'(valid_o), 64'd0);
    check("midreset busy", 64'(busy_o), 64'd0);
    check("midreset quot", 64'(quot_o), 64'd0);
    check("midreset rem", 64'(rem_o), 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
    end
    check("midreset no valid", 64'(seen), 64'd0);
    do_op("after reset", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
